// File: rtl/vx_tcu_drl_align.sv
// Exponent alignment front end of the TCU dot-product significand path.
// Two-stage elastic pipeline: max-exponent/diff, then shift, sticky and two's-complement conversion.
module vx_tcu_drl_align #(
    parameter string INSTANCE_ID = "",
    parameter int    N  = 5,
    parameter int    WM = 22,
    parameter int    WI = 26,
    parameter int    WE = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [31:0]       req_id,
    input  logic [N-2:0]      lane_mask,
    input  logic [N*WE-1:0]   exps_in,
    input  logic [N*WM-1:0]   mags_in,
    input  logic [N-1:0]      signs_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [31:0]       req_id_out,
    output logic [N-2:0]      lane_mask_out,
    output logic [WE-1:0]     max_exp,
    output logic [N*WI-1:0]   sigs_out,
    output logic [N-1:0]      sticky_out
);

    // Magnitudes are placed at the top of a WI-1 bit field; the extra sign bit brings it to WI.
    localparam int WX = WI - 1;
    localparam int WP = WI - 1 - WM;

    function automatic logic [WX-1:0] align_shift(input logic [WX-1:0] ext, input logic [WE-1:0] diff);
        logic [WX-1:0] res;
        if (32'(diff) >= 32'(WX)) begin
            res = {WX{1'b0}};
        end else begin
            res = ext >> diff;
        end
        return res;
    endfunction

    function automatic logic align_sticky(input logic [WX-1:0] ext, input logic [WE-1:0] diff);
        logic res;
        if (32'(diff) >= 32'(WX)) begin
            res = |ext;
        end else begin
            res = |(ext & ~({WX{1'b1}} << diff));
        end
        return res;
    endfunction

    function automatic logic [WI-1:0] to_twos(input logic [WX-1:0] a, input logic sign);
        logic [WI-1:0] mag_v;
        mag_v = {1'b0, a};
        return sign ? (~mag_v + {{(WI-1){1'b0}}, 1'b1}) : mag_v;
    endfunction

    logic                    en1_s;
    logic                    en2_s;
    logic [WE-1:0]           max_exp_s;
    logic [N-1:0][WE-1:0]    diff_s;
    logic [N*WI-1:0]         sigs_s;
    logic [N-1:0]            sticky_s;

    logic                    s1_valid_r;
    logic [WE-1:0]           s1_max_exp_r;
    logic [N-1:0][WE-1:0]    s1_diff_r;
    logic [N*WM-1:0]         s1_mags_r;
    logic [N-1:0]            s1_signs_r;
    logic [31:0]             s1_req_id_r;
    logic [N-2:0]            s1_mask_r;

    // Stage handshake enables; ready_out reaches ready_in only through these.
    always_comb begin
        en2_s = !valid_out | ready_out;
        en1_s = !s1_valid_r | en2_s;
    end

    assign ready_in = en1_s;

    // Maximum exponent over non-zero lanes and per-lane shift distances.
    always_comb begin
        max_exp_s = {WE{1'b0}};
        diff_s    = '0;
        for (int i = 0; i < N; i++) begin
            max_exp_s = ((mags_in[i*WM +: WM] != {WM{1'b0}}) && (exps_in[i*WE +: WE] > max_exp_s))
                        ? exps_in[i*WE +: WE] : max_exp_s;
        end
        for (int i = 0; i < N; i++) begin
            diff_s[i] = (mags_in[i*WM +: WM] != {WM{1'b0}})
                        ? (max_exp_s - exps_in[i*WE +: WE]) : {WE{1'b0}};
        end
    end

    // Shift, sticky collection and sign application for each lane.
    always_comb begin
        sigs_s   = '0;
        sticky_s = '0;
        for (int i = 0; i < N; i++) begin
            sigs_s[i*WI +: WI] = to_twos(align_shift({s1_mags_r[i*WM +: WM], {WP{1'b0}}}, s1_diff_r[i]),
                                         s1_signs_r[i]);
            sticky_s[i]        = align_sticky({s1_mags_r[i*WM +: WM], {WP{1'b0}}}, s1_diff_r[i]);
        end
    end

    // Stage 1 and stage 2 registers; data only loads with a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r    <= 1'b0;
            s1_max_exp_r  <= {WE{1'b0}};
            s1_diff_r     <= '0;
            s1_mags_r     <= '0;
            s1_signs_r    <= '0;
            s1_req_id_r   <= 32'h0000_0000;
            s1_mask_r     <= '0;
            valid_out     <= 1'b0;
            req_id_out    <= 32'h0000_0000;
            lane_mask_out <= '0;
            max_exp       <= {WE{1'b0}};
            sigs_out      <= '0;
            sticky_out    <= '0;
        end else begin
            if (en1_s) begin
                s1_valid_r <= valid_in;
                if (valid_in) begin
                    s1_max_exp_r <= max_exp_s;
                    s1_diff_r    <= diff_s;
                    s1_mags_r    <= mags_in;
                    s1_signs_r   <= signs_in;
                    s1_req_id_r  <= req_id;
                    s1_mask_r    <= lane_mask;
                end
            end
            if (en2_s) begin
                valid_out <= s1_valid_r;
                if (s1_valid_r) begin
                    req_id_out    <= s1_req_id_r;
                    lane_mask_out <= s1_mask_r;
                    max_exp       <= s1_max_exp_r;
                    sigs_out      <= sigs_s;
                    sticky_out    <= sticky_s;
                end
            end
        end
    end

`ifdef DBG_TRACE_TCU
    // Debug trace of every accepted output beat.
    always_ff @(posedge clk) begin
        if (!reset && valid_out && ready_out) begin
            $display("%t: %s req_id=%0h max_exp=%0d sigs=%h sticky=%b",
                     $time, INSTANCE_ID, req_id_out, max_exp, sigs_out, sticky_out);
        end
    end
`endif

endmodule

// File: tb/tb_vx_tcu_drl_align.sv
// Directed bench for vx_tcu_drl_align: vector table for alignment results,
// plus hand-written backpressure and mid-flight reset sequences.
module tb_vx_tcu_drl_align;

    localparam int N  = 5;
    localparam int WM = 22;
    localparam int WI = 26;
    localparam int WE = 10;

    typedef struct {
        logic [31:0]          req;
        logic [N-2:0]         mask;
        logic [N-1:0][WE-1:0] exps;
        logic [N-1:0][WM-1:0] mags;
        logic [N-1:0]         signs;
        logic [WE-1:0]        max_exp;
        logic [N-1:0][WI-1:0] sigs;
        logic [N-1:0]         sticky;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic              ready_in;
    logic [31:0]       req_id;
    logic [N-2:0]      lane_mask;
    logic [N*WE-1:0]   exps_in;
    logic [N*WM-1:0]   mags_in;
    logic [N-1:0]      signs_in;
    logic              valid_out;
    logic              ready_out;
    logic [31:0]       req_id_out;
    logic [N-2:0]      lane_mask_out;
    logic [WE-1:0]     max_exp;
    logic [N*WI-1:0]   sigs_out;
    logic [N-1:0]      sticky_out;

    int vectors     = 0;
    int miscompares = 0;

    vx_tcu_drl_align #(.INSTANCE_ID("tb"), .N(N), .WM(WM), .WI(WI), .WE(WE)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .req_id(req_id), .lane_mask(lane_mask), .exps_in(exps_in), .mags_in(mags_in),
        .signs_in(signs_in), .valid_out(valid_out), .ready_out(ready_out),
        .req_id_out(req_id_out), .lane_mask_out(lane_mask_out), .max_exp(max_exp),
        .sigs_out(sigs_out), .sticky_out(sticky_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] r, input logic [N-2:0] m, input int mx);
        vec_t v;
        v.req = r; v.mask = m; v.max_exp = WE'(mx);
        v.exps = '0; v.mags = '0; v.signs = '0; v.sigs = '0; v.sticky = '0;
        return v;
    endfunction

    function automatic void lane(inout vec_t v, input int l, input int e, input int m,
                                 input bit s, input int sig, input bit st);
        v.exps[l] = WE'(e); v.mags[l] = WM'(m); v.signs[l] = s;
        v.sigs[l] = WI'(sig); v.sticky[l] = st;
    endfunction

    task automatic drive(input vec_t v);
        req_id = v.req; lane_mask = v.mask; exps_in = v.exps; mags_in = v.mags; signs_in = v.signs;
    endtask

    vec_t vt[6];

    initial begin
        int sent, recv, stall_left, extra;
        bit first_done, saw_block, prev_stall;
        logic [31:0]     snap_id;
        logic [WE-1:0]   snap_exp;
        logic [N*WI-1:0] snap_sigs;

        // basic alignment
        vt[0] = mk(32'h1, 4'b1111, 130);
        lane(vt[0], 0, 130, 'h200000, 1'b0, 'h1000000, 1'b0);
        lane(vt[0], 1, 128, 'h200000, 1'b0, 'h0400000, 1'b0);
        // negative and sticky, masked lanes still aligned
        vt[1] = mk(32'h2, 4'b0010, 130);
        lane(vt[1], 0, 130, 'h200000, 1'b0, 'h1000000, 1'b0);
        lane(vt[1], 2, 130, 'h200000, 1'b1, 'h3000000, 1'b0);
        lane(vt[1], 3, 125, 'h000001, 1'b0, 0, 1'b1);
        // shift saturation on the C lane
        vt[2] = mk(32'h3, 4'b1000, 200);
        lane(vt[2], 4, 100, 'h3FFFFF, 1'b0, 0, 1'b1);
        lane(vt[2], 0, 200, 'h000001, 1'b0, 'h8, 1'b0);
        // all zero magnitudes with arbitrary exponents and signs
        vt[3] = mk(32'h4, 4'b0110, 0);
        lane(vt[3], 0, 500, 0, 1'b1, 0, 1'b0);
        lane(vt[3], 1, 3, 0, 1'b1, 0, 1'b0);
        lane(vt[3], 2, 1023, 0, 1'b1, 0, 1'b0);
        lane(vt[3], 3, 7, 0, 1'b1, 0, 1'b0);
        lane(vt[3], 4, 900, 0, 1'b1, 0, 1'b0);
        // shift of WI-2 and WI-1; zero lane with large exponent ignored
        vt[4] = mk(32'h5, 4'b1001, 50);
        lane(vt[4], 0, 50, 'h3FFFFF, 1'b0, 'h1FFFFF8, 1'b0);
        lane(vt[4], 1, 26, 'h3FFFFF, 1'b0, 1, 1'b1);
        lane(vt[4], 2, 25, 'h3FFFFF, 1'b0, 0, 1'b1);
        lane(vt[4], 3, 1000, 0, 1'b1, 0, 1'b0);
        // negative shifted to zero, exact and inexact small shifts, C lane holds the max
        vt[5] = mk(32'hDEADBEEF, 4'b0101, 301);
        lane(vt[5], 0, 300, 'h000100, 1'b0, 'h400, 1'b0);
        lane(vt[5], 1, 200, 'h155555, 1'b1, 0, 1'b1);
        lane(vt[5], 2, 298, 'h000003, 1'b1, 'h3FFFFFD, 1'b0);
        lane(vt[5], 3, 297, 'h000003, 1'b0, 1, 1'b1);
        lane(vt[5], 4, 301, 'h000004, 1'b1, 'h3FFFFE0, 1'b0);

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
        req_id = '0; lane_mask = '0; exps_in = '0; mags_in = '0; signs_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid_out", 160'(valid_out), 160'(0));
        chk("rst.data", 160'({req_id_out, max_exp, sticky_out, lane_mask_out}), 160'(0));
        chk("rst.sigs", 160'(sigs_out), 160'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready_in", 160'(ready_in), 160'(1));

        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(vt[k]); valid_in = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            chk($sformatf("v%0d.latency", k), 160'(valid_out), 160'(0));
            @(posedge clk); #1;
            chk($sformatf("v%0d.valid", k), 160'(valid_out), 160'(1));
            chk($sformatf("v%0d.req_id", k), 160'(req_id_out), 160'(vt[k].req));
            chk($sformatf("v%0d.mask", k), 160'(lane_mask_out), 160'(vt[k].mask));
            chk($sformatf("v%0d.max_exp", k), 160'(max_exp), 160'(vt[k].max_exp));
            chk($sformatf("v%0d.sigs", k), 160'(sigs_out), 160'(vt[k].sigs));
            chk($sformatf("v%0d.sticky", k), 160'(sticky_out), 160'(vt[k].sticky));
        end

        // backpressure: four beats, three stall cycles after the first output
        sent = 0; recv = 0; stall_left = 0; extra = 0;
        first_done = 1'b0; saw_block = 1'b0; prev_stall = 1'b0;
        snap_id = '0; snap_exp = '0; snap_sigs = '0;
        @(posedge clk);
        for (int c = 0; c < 40 && recv < 4; c++) begin
            #1;
            if (stall_left > 0) begin ready_out = 1'b0; stall_left--; end
            else ready_out = 1'b1;
            if (sent < 4) begin drive(vt[0]); req_id = 32'(sent + 1); valid_in = 1'b1; end
            else valid_in = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                chk("bp.stable_id", 160'(req_id_out), 160'(snap_id));
                chk("bp.stable_exp", 160'(max_exp), 160'(snap_exp));
                chk("bp.stable_sigs", 160'(sigs_out), 160'(snap_sigs));
            end
            if (valid_out && ready_out) begin
                chk("bp.order", 160'(req_id_out), 160'(recv + 1));
                recv++;
                if (!first_done) begin first_done = 1'b1; stall_left = 3; end
            end
            prev_stall = valid_out && !ready_out;
            snap_id = req_id_out; snap_exp = max_exp; snap_sigs = sigs_out;
            if (valid_in && !ready_in) saw_block = 1'b1;
            if (valid_in && ready_in) sent++;
            @(posedge clk);
        end
        chk("bp.received", 160'(recv), 160'(4));
        chk("bp.ready_in_low", 160'(saw_block), 160'(1));
        #1; valid_in = 1'b0; ready_out = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (valid_out) extra++;
        end
        chk("bp.no_dup", 160'(extra), 160'(0));

        // reset with both stages full
        @(posedge clk); #1;
        ready_out = 1'b0; drive(vt[5]); req_id = 32'hA; valid_in = 1'b1;
        @(posedge clk); #1;
        req_id = 32'hB;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("mid.full_valid", 160'(valid_out), 160'(1));
        chk("mid.full_ready_in", 160'(ready_in), 160'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid.valid_out", 160'(valid_out), 160'(0));
        chk("mid.data", 160'({req_id_out, max_exp, sticky_out, lane_mask_out}), 160'(0));
        chk("mid.sigs", 160'(sigs_out), 160'(0));
        reset = 1'b0; ready_out = 1'b1;
        extra = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (valid_out) extra++;
        end
        chk("mid.no_stale", 160'(extra), 160'(0));
        chk("mid.ready_in", 160'(ready_in), 160'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
